fp_mul_sequencer: RTL and testbench

Issue/collect sequencer that sits directly upstream of the floating-point multiplier. It accepts operand pairs from the core over a valid/ready handshake and holds them stable while driving the multiplier's `run`/`stall` protocol. It captures the 32-bit product and returns it with a tag and status flags over a second valid/ready handshake. It also short-circuits zero operands and guards against a hung multiplier with a watchdog.

---
 rtl/fp_mul_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_fp_mul_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_sequencer.sv
// fp_mul_sequencer
//
// This block issues operand pairs to the floating-point multiplier and collects
// the results. It accepts one request at a time from the core and holds the
// operands stable on mul_x/mul_y while driving mul_run. When the multiplier
// lowers mul_stall, the block captures mul_z and returns it with the request
// tag and status flags.
//
// Zero-exponent operands can skip the multiplier entirely (FASTZERO). A
// watchdog ends a RUN phase that lasts TIMEOUT cycles and returns a
// timeout-flagged response.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   req_valid  request present          req_ready  request can be accepted
//   req_x/y    IEEE single operands      req_tag    opaque tag echoed back
//   mul_run    run strobe to multiplier  mul_x/y    held operands to multiplier
//   mul_stall  multiplier busy           mul_z      multiplier result
//   rsp_valid  response present          rsp_ready  consumer accepts response
//   rsp_z      product                   rsp_tag    echoed tag
//   rsp_flags  [0] zero exponent, [1] saturated exponent, [2] watchdog timeout
//   busy       sequencer is not idle
module fp_mul_sequencer #(
  parameter int TAGW     = 4,
  parameter int TIMEOUT  = 40,
  parameter int FASTZERO = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_x,
  input  logic [31:0]     req_y,
  input  logic [TAGW-1:0] req_tag,
  output logic            mul_run,
  output logic [31:0]     mul_x,
  output logic [31:0]     mul_y,
  input  logic            mul_stall,
  input  logic [31:0]     mul_z,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_z,
  output logic [TAGW-1:0] rsp_tag,
  output logic [2:0]      rsp_flags,
  output logic            busy
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when the biased exponent field of an IEEE single is all zeros.
  function automatic logic exp_is_zero(input logic [31:0] v);
    return (v[30:23] == 8'd0);
  endfunction

  // True when the biased exponent field of an IEEE single is all ones.
  function automatic logic exp_is_max(input logic [31:0] v);
    return (v[30:23] == 8'hFF);
  endfunction

  state_t          state_r, next_state_s;
  logic [31:0]     mul_x_r, next_mul_x_s;
  logic [31:0]     mul_y_r, next_mul_y_s;
  logic [31:0]     rsp_z_r, next_rsp_z_s;
  logic [TAGW-1:0] rsp_tag_r, next_rsp_tag_s;
  logic [2:0]      rsp_flags_r, next_rsp_flags_s;
  logic [WDW-1:0]  wd_cnt_r, next_wd_cnt_s;
  logic [WDW-1:0]  wd_inc_s;
  logic            mul_run_r, next_mul_run_s;
  logic            rsp_valid_r, next_rsp_valid_s;
  logic            busy_r, next_busy_s;
  logic            accept_s;
  logic            fast_zero_s;

  // req_ready is qualified by rst so that no request is taken while reset is held.
  assign req_ready = rst & (state_r == IDLE);
  assign accept_s  = req_valid & req_ready;

  // A fast-zero request never reaches the multiplier.
  assign fast_zero_s = (FASTZERO != 0) && (exp_is_zero(req_x) || exp_is_zero(req_y));

  // The watchdog increment saturates at TIMEOUT.
  assign wd_inc_s = (wd_cnt_r == WD_MAX) ? wd_cnt_r : (wd_cnt_r + {{(WDW-1){1'b0}}, 1'b1});

  // Next-state and next-register logic for the sequencer FSM.
  always_comb begin
    next_state_s     = state_r;
    next_mul_x_s     = mul_x_r;
    next_mul_y_s     = mul_y_r;
    next_rsp_z_s     = rsp_z_r;
    next_rsp_tag_s   = rsp_tag_r;
    next_rsp_flags_s = rsp_flags_r;
    next_wd_cnt_s    = wd_cnt_r;

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_mul_x_s   = req_x;
          next_mul_y_s   = req_y;
          next_rsp_tag_s = req_tag;
          if (fast_zero_s) begin
            next_rsp_z_s     = 32'd0;
            next_rsp_flags_s = 3'b001;
            next_state_s     = DONE;
          end else begin
            next_wd_cnt_s = {WDW{1'b0}};
            next_state_s  = RUN;
          end
        end else begin
          next_state_s = IDLE;
        end
      end

      RUN: begin
        // A completing result takes priority over a timeout in the same cycle.
        if (!mul_stall) begin
          next_rsp_z_s     = mul_z;
          next_rsp_flags_s = {1'b0, exp_is_max(mul_z), exp_is_zero(mul_z)};
          next_wd_cnt_s    = wd_inc_s;
          next_state_s     = DONE;
        end else if (wd_inc_s == WD_MAX) begin
          next_rsp_z_s     = 32'd0;
          next_rsp_flags_s = 3'b100;
          next_wd_cnt_s    = wd_inc_s;
          next_state_s     = DONE;
        end else begin
          next_wd_cnt_s = wd_inc_s;
          next_state_s  = RUN;
        end
      end

      DONE: begin
        // Response fields stay stable until the consumer takes them.
        if (rsp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end

      default: begin
        next_state_s = IDLE;
      end
    endcase

    // Registered copies of the state decode keep these outputs glitch-free.
    next_mul_run_s   = (next_state_s == RUN);
    next_rsp_valid_s = (next_state_s == DONE);
    next_busy_s      = (next_state_s != IDLE);
  end

  // State and datapath registers with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      mul_x_r     <= 32'd0;
      mul_y_r     <= 32'd0;
      rsp_z_r     <= 32'd0;
      rsp_tag_r   <= {TAGW{1'b0}};
      rsp_flags_r <= 3'b000;
      wd_cnt_r    <= {WDW{1'b0}};
      mul_run_r   <= 1'b0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      mul_x_r     <= next_mul_x_s;
      mul_y_r     <= next_mul_y_s;
      rsp_z_r     <= next_rsp_z_s;
      rsp_tag_r   <= next_rsp_tag_s;
      rsp_flags_r <= next_rsp_flags_s;
      wd_cnt_r    <= next_wd_cnt_s;
      mul_run_r   <= next_mul_run_s;
      rsp_valid_r <= next_rsp_valid_s;
      busy_r      <= next_busy_s;
    end
  end

  assign mul_run   = mul_run_r;
  assign mul_x     = mul_x_r;
  assign mul_y     = mul_y_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_z     = rsp_z_r;
  assign rsp_tag   = rsp_tag_r;
  assign rsp_flags = rsp_flags_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_fp_mul_sequencer.sv
// Testbench for fp_mul_sequencer.
//
// A multiplier stub answers in its 26th run cycle, or never when hang is set.
// The stimulus process issues directed requests and pushes each hand-computed
// response into a scoreboard queue. A monitor process compares every response
// the sequencer presents against that queue.
module tb_fp_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_x, req_y;
  logic [3:0]  req_tag;
  logic        mul_run;
  logic [31:0] mul_x, mul_y;
  logic        mul_stall;
  logic [31:0] mul_z;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_z;
  logic [3:0]  rsp_tag;
  logic [2:0]  rsp_flags;
  logic        busy;

  always #5 clk = ~clk;

  fp_mul_sequencer #(.TAGW(4), .TIMEOUT(40), .FASTZERO(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_tag(req_tag),
    .mul_run(mul_run), .mul_x(mul_x), .mul_y(mul_y),
    .mul_stall(mul_stall), .mul_z(mul_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_tag(rsp_tag), .rsp_flags(rsp_flags),
    .busy(busy)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Edge counter and count of run-high cycles.
  int cyc = 0;
  int run_total = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mul_run) run_total <= run_total + 1;
  end

  // Behavioural single-precision multiply: truncating, flush-to-zero, saturate to exponent 255.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] p;
    logic [22:0] m;
    s = a[31] ^ b[31];
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    if (p[47]) begin
      m = p[46:24];
      e = int'(a[30:23]) + int'(b[30:23]) - 126;
    end else begin
      m = p[45:23];
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    else if (e <= 0) return {s, 31'd0};
    else return {s, e[7:0], m};
  endfunction

  // Multiplier stub: stall drops in the 26th run cycle, and the stub flags operand changes during a run.
  logic        hang = 1'b0;
  int          scnt = 0;
  int          hold_err = 0;
  logic [31:0] cap_x = 32'd0, cap_y = 32'd0;
  always @(posedge clk) begin
    if (mul_run) begin
      if (scnt == 0) begin
        cap_x <= mul_x;
        cap_y <= mul_y;
      end else if (mul_x !== cap_x || mul_y !== cap_y) begin
        hold_err <= hold_err + 1;
      end
      scnt <= scnt + 1;
    end else begin
      scnt <= 0;
    end
  end
  assign mul_stall = hang | ~(mul_run & (scnt == 25));
  assign mul_z     = fmul(mul_x, mul_y);

  typedef struct {
    logic [31:0] z;
    logic [3:0]  tag;
    logic [2:0]  flags;
    int          lat;
    int          runs;
    int          acc;
    int          rbase;
    logic [31:0] x;
    logic [31:0] y;
  } exp_t;
  exp_t sbq[$];

  // Monitor: compares on first sight of a response, then tracks stability until the handshake.
  logic        in_rsp = 1'b0;
  logic        stable;
  logic [31:0] s_z;
  logic [3:0]  s_tag;
  logic [2:0]  s_fl;
  always @(negedge clk) begin
    if (!rst) begin
      in_rsp = 1'b0;
    end else if (rsp_valid) begin
      if (!in_rsp) begin
        in_rsp = 1'b1;
        s_z = rsp_z; s_tag = rsp_tag; s_fl = rsp_flags;
        stable = 1'b1;
        check("rsp_has_request", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          check($sformatf("rsp_z tag%0d", sbq[0].tag), rsp_z, sbq[0].z);
          check($sformatf("rsp_tag tag%0d", sbq[0].tag), 32'(rsp_tag), 32'(sbq[0].tag));
          check($sformatf("rsp_flags tag%0d", sbq[0].tag), 32'(rsp_flags), 32'(sbq[0].flags));
          check($sformatf("latency tag%0d", sbq[0].tag), cyc - sbq[0].acc, sbq[0].lat);
          check($sformatf("run_cycles tag%0d", sbq[0].tag), run_total - sbq[0].rbase, sbq[0].runs);
          check($sformatf("run_low_in_done tag%0d", sbq[0].tag), 32'(mul_run), 32'd0);
          if (sbq[0].runs > 0) begin
            check($sformatf("mul_x tag%0d", sbq[0].tag), cap_x, sbq[0].x);
            check($sformatf("mul_y tag%0d", sbq[0].tag), cap_y, sbq[0].y);
            check($sformatf("operands_held tag%0d", sbq[0].tag), hold_err, 32'd0);
          end
        end
      end else if (rsp_z !== s_z || rsp_tag !== s_tag || rsp_flags !== s_fl || req_ready || mul_run) begin
        stable = 1'b0;
      end
      if (rsp_ready) begin
        check("rsp_stable_until_taken", 32'(stable), 32'd1);
        if (sbq.size() != 0) void'(sbq.pop_front());
        in_rsp = 1'b0;
      end
    end
  end

  // Drive one request until accepted; the acceptance edge is returned in acc.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [3:0] tag,
                       input logic [31:0] ez, input logic [2:0] ef, input int elat,
                       input int eruns, input bit push, output int acc);
    int   n = 0;
    exp_t e;
    req_valid = 1'b1; req_x = x; req_y = y; req_tag = tag;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", 32'(n < 200), 32'd1);
    acc = cyc + 1;
    if (push) begin
      e.z = ez; e.tag = tag; e.flags = ef; e.lat = elat; e.runs = eruns;
      e.acc = acc; e.rbase = run_total; e.x = x; e.y = y;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Wait until every expected response has been taken and the sequencer is idle.
  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < 500), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a1, a2, h, n;
    rst = 1'b0; req_valid = 1'b0; req_x = 32'd0; req_y = 32'd0; req_tag = 4'd0;
    rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset mul_run", 32'(mul_run), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset mul_x", mul_x, 32'd0);
    check("reset mul_y", mul_y, 32'd0);
    check("reset rsp_z", rsp_z, 32'd0);
    check("reset rsp_tag", 32'(rsp_tag), 32'd0);
    check("reset rsp_flags", 32'(rsp_flags), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("req_ready after release", 32'(req_ready), 32'd1);

    // Normal product 1.0 * 2.0
    issue(32'h3F800000, 32'h40000000, 4'd5, 32'h40000000, 3'b000, 26, 26, 1'b1, a1);
    drain();

    // Fast zero on x, then on y, back to back: one accept every 2 clocks
    issue(32'h00000000, 32'h40400000, 4'd6, 32'h0, 3'b001, 0, 0, 1'b1, a1);
    issue(32'h40400000, 32'h00400000, 4'd7, 32'h0, 3'b001, 0, 0, 1'b1, a2);
    check("fast_zero throughput", a2 - a1, 32'd2);
    drain();

    // Saturation
    issue(32'h7F000000, 32'h7F000000, 4'd8, 32'h7F800000, 3'b010, 26, 26, 1'b1, a1);
    drain();

    // 3.0 * 4.0 followed by an underflow to zero through the multiplier: one accept every 28 clocks
    issue(32'h40400000, 32'h40800000, 4'd9, 32'h41400000, 3'b000, 26, 26, 1'b1, a1);
    issue(32'h00800000, 32'h3F000000, 4'd10, 32'h00000000, 3'b001, 26, 26, 1'b1, a2);
    check("normal throughput", a2 - a1, 32'd28);
    drain();

    // Backpressure: -1.5 * 2.0 held for 10 cycles, then one rsp_ready pulse and a back-to-back request
    rsp_ready = 1'b0;
    issue(32'hBFC00000, 32'h40000000, 4'd11, 32'hC0400000, 3'b000, 26, 26, 1'b1, a1);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp rsp_valid in time", 32'(rsp_valid), 32'd1);
    repeat (10) @(negedge clk);
    check("bp req_ready low", 32'(req_ready), 32'd0);
    check("bp mul_run low", 32'(mul_run), 32'd0);
    check("bp rsp_valid held", 32'(rsp_valid), 32'd1);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    h = cyc;
    check("bp req_ready after pulse", 32'(req_ready), 32'd1);
    issue(32'h40000000, 32'h3F800000, 4'd12, 32'h40000000, 3'b000, 26, 26, 1'b1, a2);
    check("bp back_to_back accept", a2 - h, 32'd1);
    rsp_ready = 1'b1;
    drain();

    // Watchdog: the multiplier never finishes
    hang = 1'b1;
    issue(32'h3F800000, 32'h3F800000, 4'd13, 32'h0, 3'b100, 40, 40, 1'b1, a1);
    drain();
    hang = 1'b0;

    // Reset during RUN cycle 10: no response; a fresh product then completes normally
    issue(32'h40000000, 32'h40000000, 4'd14, 32'h0, 3'b000, 0, 0, 1'b0, a1);
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrun mul_run before reset edge", 32'(mul_run), 32'd1);
    @(negedge clk);
    check("midrun mul_run", 32'(mul_run), 32'd0);
    check("midrun rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrun busy", 32'(busy), 32'd0);
    check("midrun req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrun req_ready after release", 32'(req_ready), 32'd1);
    issue(32'h40000000, 32'h40000000, 4'd15, 32'h40800000, 3'b000, 26, 26, 1'b1, a1);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
